// File: rtl/pcpi_pkg.sv
// pcpi_pkg: definitions shared by the PCPI initiator, its watchdog and the
// coprocessor/test code that builds instruction words.
//   pcpi_init_state_t : initiator FSM encoding (IDLE / ISSUE / RESP)
//   OPC_* / F7_* / F3_* : RISC-V opcode, funct7 and funct3 values used by the
//                         M-extension and custom-instruction coprocessors
//   rtype()            : assembles an R-type instruction word
package pcpi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } pcpi_init_state_t;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] F7_MULDIV   = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Build an R-type word: funct7 | rs2 | rs1 | funct3 | rd | opcode.
  function automatic logic [31:0] rtype(input logic [6:0] funct7,
                                        input logic [4:0] rs2,
                                        input logic [4:0] rs1,
                                        input logic [2:0] funct3,
                                        input logic [4:0] rd,
                                        input logic [6:0] opcode);
    return {funct7, rs2, rs1, funct3, rd, opcode};
  endfunction

endpackage

// File: rtl/pcpi_watchdog.sv
// pcpi_watchdog: no-claim timeout counter for the PCPI initiator.
// Counts consecutive enabled cycles with busy low; any busy cycle restarts
// the count. expired is high in the cycle where the count has reached
// TIMEOUT-1 and busy is still low, i.e. the TIMEOUT-th unclaimed cycle.
//   clk, resetn : clock, asynchronous active-low reset
//   clr         : synchronous clear (new instruction accepted)
//   en          : count enable (instruction offered)
//   busy        : OR of responder busy lines
//   expired     : unclaimed-instruction indication
module pcpi_watchdog
  import pcpi_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  input  logic busy,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear on new instruction, restart on busy, else count up.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      if (busy) begin
        cnt_d = 8'd0;
      end else if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && !busy && (cnt_q == LAST);

endmodule

// File: rtl/pcpi_initiator.sv
// pcpi_initiator: master side of the PCPI coprocessor interface.
// Takes one instruction + two operands on a valid/ready request port, offers
// it to PCPI responders, waits for pcpi_ready (or traps after TIMEOUT
// unclaimed cycles) and returns the result on a valid/ready response port.
//   clk, resetn                      : clock, asynchronous active-low reset
//   req_valid/req_ready              : request handshake
//   req_insn/req_rs1/req_rs2         : instruction and operands
//   pcpi_valid/insn/rs1/rs2 (out)    : instruction offered to responders
//   pcpi_wr/rd/busy/ready (in)       : responder result and status
//   resp_valid/resp_ready            : response handshake
//   resp_rd/resp_wr/resp_trap        : captured result, trap = unclaimed
//   resp_cycles                      : cycles pcpi_valid was high (saturating)
// Every output comes straight from a flop.
module pcpi_initiator
  import pcpi_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CYC_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_insn,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  output logic             pcpi_valid,
  output logic [31:0]      pcpi_insn,
  output logic [31:0]      pcpi_rs1,
  output logic [31:0]      pcpi_rs2,
  input  logic             pcpi_wr,
  input  logic [31:0]      pcpi_rd,
  input  logic             pcpi_busy,
  input  logic             pcpi_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rd,
  output logic             resp_wr,
  output logic             resp_trap,
  output logic [CYC_W-1:0] resp_cycles
);

  localparam logic [CYC_W-1:0] CYC_MAX = {CYC_W{1'b1}};
  localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

  pcpi_init_state_t state_q, state_d;

  logic             req_ready_q, req_ready_d;
  logic             pcpi_valid_q, pcpi_valid_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      insn_q, insn_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [31:0]      rd_q, rd_d;
  logic             wr_q, wr_d;
  logic             trap_q, trap_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;

  logic wd_clr;
  logic wd_en;
  logic wd_expired;

  pcpi_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (wd_clr),
    .en      (wd_en),
    .busy    (pcpi_busy),
    .expired (wd_expired)
  );

  // Next-state, datapath capture and registered-output decode.
  always_comb begin
    state_d = state_q;
    insn_d  = insn_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    trap_d  = trap_q;
    cyc_d   = cyc_q;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;

    case (state_q)
      IDLE: begin
        // req_ready_q gates acceptance so nothing is taken in the first
        // cycle after reset release, while req_ready is still low.
        if (req_valid && req_ready_q) begin
          insn_d  = req_insn;
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          cyc_d   = {CYC_W{1'b0}};
          wd_clr  = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        wd_en = 1'b1;
        cyc_d = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + CYC_ONE;
        // A ready in the same cycle as expiry wins over the trap.
        if (pcpi_ready) begin
          rd_d    = pcpi_rd;
          wr_d    = pcpi_wr;
          trap_d  = 1'b0;
          state_d = RESP;
        end else if (wd_expired) begin
          rd_d    = 32'h0000_0000;
          wr_d    = 1'b0;
          trap_d  = 1'b1;
          state_d = RESP;
        end else begin
          state_d = ISSUE;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d  = (state_d == IDLE);
    pcpi_valid_d = (state_d == ISSUE);
    resp_valid_d = (state_d == RESP);
  end

  // State, handshake flags and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      pcpi_valid_q <= 1'b0;
      resp_valid_q <= 1'b0;
      insn_q       <= 32'h0000_0000;
      rs1_q        <= 32'h0000_0000;
      rs2_q        <= 32'h0000_0000;
      rd_q         <= 32'h0000_0000;
      wr_q         <= 1'b0;
      trap_q       <= 1'b0;
      cyc_q        <= {CYC_W{1'b0}};
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      pcpi_valid_q <= pcpi_valid_d;
      resp_valid_q <= resp_valid_d;
      insn_q       <= insn_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      trap_q       <= trap_d;
      cyc_q        <= cyc_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign pcpi_valid  = pcpi_valid_q;
  assign pcpi_insn   = insn_q;
  assign pcpi_rs1    = rs1_q;
  assign pcpi_rs2    = rs2_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rd     = rd_q;
  assign resp_wr     = wr_q;
  assign resp_trap   = trap_q;
  assign resp_cycles = cyc_q;

endmodule

// File: tb/tb_pcpi_initiator.sv
// tb_pcpi_initiator: self-checking bench for pcpi_initiator.
// A behavioural responder (M-extension MUL/DIVU, a long-busy custom unit and
// a busy-then-silent unit) sits on the PCPI side. A transaction-level model
// holds, per request, the result and the number of cycles the instruction is
// offered; one negedge process checks every DUT output against it.
module tb_pcpi_initiator;
  import pcpi_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_insn = 32'h0;
  logic [31:0] req_rs1 = 32'h0;
  logic [31:0] req_rs2 = 32'h0;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr = 1'b0;
  logic [31:0] pcpi_rd = 32'h0;
  logic        pcpi_busy = 1'b0;
  logic        pcpi_ready = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rd;
  logic        resp_wr, resp_trap;
  logic [15:0] resp_cycles;

  pcpi_initiator #(.TIMEOUT(TO), .CYC_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_busy(pcpi_busy), .pcpi_ready(pcpi_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd(resp_rd), .resp_wr(resp_wr), .resp_trap(resp_trap),
    .resp_cycles(resp_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn, rs1, rs2, rd;
    logic        wr, trap;
    int          cyc;   // cycles the instruction stays offered
  } txn_t;

  txn_t pend[$];
  txn_t cur;
  int   n_chk = 0, n_pass = 0;
  int   tb_cyc = 0, crs = 0, h = 0, hs_count = 0;
  bit   active = 1'b0, resp_seen = 1'b0;
  int   hs_log[$];
  int   obs_first = 0, obs_len = 0, obs_cyc = 0;
  logic [31:0] obs_rd = 32'h0;
  logic obs_wr = 1'b0, obs_trap = 1'b0;
  int   rsp_mode = 1;   // 0 none, 1 M-ext, 2 long busy, 3 busy then silent
  bit   stray = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, tb_cyc);
  endtask

  task automatic fail_bound(input string nm);
    n_chk++;
    $display("FAIL %s: got bound expired required completion (cycle %0d)", nm, tb_cyc);
  endtask

  // Behavioural PCPI responder.
  initial begin
    int k, lat, bend;
    logic [31:0] val;
    k = 0;
    forever begin
      @(posedge clk); #1;
      if (pcpi_valid) k++; else k = 0;
      lat = 0; bend = 0; val = 32'h0;
      if (pcpi_valid) begin
        if (rsp_mode == 2) begin
          lat = 41; bend = 40; val = 32'hDEADBEEF;
        end else if (rsp_mode == 3) begin
          bend = 5;
        end else if (rsp_mode == 1 && pcpi_insn[6:0] == OPC_OP && pcpi_insn[31:25] == F7_MULDIV) begin
          if (pcpi_insn[14:12] == F3_MUL) begin
            lat = 3; bend = 2; val = pcpi_rs1 * pcpi_rs2;
          end else if (pcpi_insn[14:12] == F3_DIVU) begin
            lat = 35; bend = 34; val = (pcpi_rs2 == 32'h0) ? 32'hFFFF_FFFF : pcpi_rs1 / pcpi_rs2;
          end
        end
      end
      pcpi_busy  = pcpi_valid && k >= 1 && k <= bend;
      pcpi_ready = pcpi_valid && lat > 0 && k == lat;
      pcpi_wr    = pcpi_ready;
      pcpi_rd    = pcpi_ready ? val : (32'hBAD0_0000 | 32'(k));
      if (stray) begin
        pcpi_busy = 1'b1; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h5A5A_5A5A;
      end
    end
  end

  // Model + compare: every cycle, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      tb_cyc++;
      if (!resetn) begin
        crs = 0; active = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_pcpi_valid", 32'(pcpi_valid), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_pcpi_insn", pcpi_insn, 32'h0);
        chk("rst_pcpi_rs1", pcpi_rs1, 32'h0);
        chk("rst_pcpi_rs2", pcpi_rs2, 32'h0);
        chk("rst_resp_rd", resp_rd, 32'h0);
        chk("rst_resp_flags", {30'h0, resp_wr, resp_trap}, 32'h0);
        chk("rst_resp_cycles", 32'(resp_cycles), 32'h0);
      end else begin
        crs++;
        if (!active) begin
          chk("idle_req_ready", 32'(req_ready), 32'(crs >= 2));
          chk("idle_pcpi_valid", 32'(pcpi_valid), 32'h0);
          chk("idle_resp_valid", 32'(resp_valid), 32'h0);
          if (crs >= 2 && req_valid) begin
            if (pend.size() == 0) begin
              fail_bound("unexpected_request");
            end else begin
              cur = pend.pop_front();
              active = 1'b1; h = tb_cyc; hs_count++; resp_seen = 1'b0;
              hs_log.push_back(tb_cyc);
            end
          end
        end else if (tb_cyc - h <= cur.cyc) begin
          chk("issue_pcpi_valid", 32'(pcpi_valid), 32'h1);
          chk("issue_req_ready", 32'(req_ready), 32'h0);
          chk("issue_resp_valid", 32'(resp_valid), 32'h0);
          chk("issue_insn", pcpi_insn, cur.insn);
          chk("issue_rs1", pcpi_rs1, cur.rs1);
          chk("issue_rs2", pcpi_rs2, cur.rs2);
        end else begin
          if (!resp_seen) begin
            resp_seen = 1'b1; obs_first = tb_cyc - h;
          end
          chk("resp_valid", 32'(resp_valid), 32'h1);
          chk("resp_pcpi_valid", 32'(pcpi_valid), 32'h0);
          chk("resp_req_ready", 32'(req_ready), 32'h0);
          chk("resp_rd", resp_rd, cur.rd);
          chk("resp_wr", 32'(resp_wr), 32'(cur.wr));
          chk("resp_trap", 32'(resp_trap), 32'(cur.trap));
          chk("resp_cycles", 32'(resp_cycles), 32'(cur.cyc));
          if (resp_ready) begin
            active = 1'b0;
            obs_len = tb_cyc - h - cur.cyc;
            obs_rd = resp_rd; obs_wr = resp_wr; obs_trap = resp_trap;
            obs_cyc = int'(resp_cycles);
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] rd, input logic wr, input logic trap, input int cyc);
    txn_t t;
    int target;
    bit ok;
    t.insn = insn; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.wr = wr; t.trap = trap; t.cyc = cyc;
    pend.push_back(t);
    req_insn = insn; req_rs1 = rs1; req_rs2 = rs2; req_valid = 1'b1;
    target = hs_count + 1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (hs_count >= target) begin ok = 1'b1; break; end
    end
    if (!ok) fail_bound("handshake");
    #1;
    req_valid = 1'b0; req_insn = 32'hFFFF_FFFF; req_rs1 = 32'h1234_5678; req_rs2 = 32'h8765_4321;
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (!active && pend.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) fail_bound(nm);
    #1;
  endtask

  logic [31:0] mul_i, divu_i;

  initial begin
    mul_i  = rtype(F7_MULDIV, 5'd2, 5'd1, F3_MUL, 5'd3, OPC_OP);
    divu_i = rtype(F7_MULDIV, 5'd2, 5'd1, F3_DIVU, 5'd3, OPC_OP);
    chk("rtype_mul", mul_i, 32'h022081B3);
    chk("rtype_divu", divu_i, 32'h0220D1B3);

    #1 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // MUL 7*6
    issue(mul_i, 32'd7, 32'd6, 32'd7 * 32'd6, 1'b1, 1'b0, 3);
    wait_done("mul_done");
    chk("mul_rd_lit", obs_rd, 32'd42);
    chk("mul_wr_lit", 32'(obs_wr), 32'h1);
    chk("mul_latency_lit", 32'(obs_first), 32'd4);

    // DIVU 100/7
    issue(divu_i, 32'd100, 32'd7, 32'd100 / 32'd7, 1'b1, 1'b0, 35);
    wait_done("divu_done");
    chk("divu_rd_lit", obs_rd, 32'd14);
    chk("divu_cycles_lit", 32'(obs_cyc), 32'd35);

    // Unclaimed instruction
    issue(32'h0000_0013, 32'd1, 32'd2, 32'h0, 1'b0, 1'b1, TO);
    wait_done("trap_done");
    chk("trap_lit", 32'(obs_trap), 32'h1);
    chk("trap_first_lit", 32'(obs_first), 32'd17);
    chk("trap_cycles_lit", 32'(obs_cyc), 32'd16);
    chk("trap_rd_lit", obs_rd, 32'h0);

    // Long busy custom unit
    rsp_mode = 2;
    issue(rtype(7'd0, 5'd4, 5'd5, 3'd0, 5'd6, OPC_CUSTOM0), 32'hA, 32'hB, 32'hDEADBEEF, 1'b1, 1'b0, 41);
    wait_done("long_done");
    chk("long_rd_lit", obs_rd, 32'hDEADBEEF);
    chk("long_cycles_lit", 32'(obs_cyc), 32'd41);
    chk("long_trap_lit", 32'(obs_trap), 32'h0);

    // Busy for 5 cycles then silence: timeout restarts after busy drops
    rsp_mode = 3;
    issue(rtype(7'd0, 5'd1, 5'd1, 3'd1, 5'd1, OPC_CUSTOM0), 32'h5, 32'h6, 32'h0, 1'b0, 1'b1, 5 + TO);
    wait_done("busy_trap_done");
    chk("busy_trap_first_lit", 32'(obs_first), 32'd22);
    rsp_mode = 1;

    // Back-pressure: resp_ready low for 5 response cycles
    resp_ready = 1'b0;
    issue(mul_i, 32'd9, 32'd9, 32'd81, 1'b1, 1'b0, 3);
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk);
        if (resp_seen) begin ok = 1'b1; break; end
      end
      if (!ok) fail_bound("bp_resp");
    end
    repeat (4) @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_done("bp_done");
    chk("bp_len_lit", 32'(obs_len), 32'd6);
    chk("bp_rd_lit", obs_rd, 32'd81);

    // Back-to-back with resp_ready high: spacing N+2
    issue(mul_i, 32'd3, 32'd5, 32'd15, 1'b1, 1'b0, 3);
    issue(mul_i, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, 1'b0, 3);
    wait_done("b2b_done");
    chk("b2b_spacing_lit", 32'(hs_log[hs_log.size()-1] - hs_log[hs_log.size()-2]), 32'd5);
    chk("b2b_rd_lit", obs_rd, 32'hFFFF_FFFE);

    // Stray ready/busy while idle must be ignored
    stray = 1'b1;
    repeat (3) @(posedge clk);
    #1 stray = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the 10th cycle of a DIVU, then a clean DIVU
    issue(divu_i, 32'd1000, 32'd9, 32'd111, 1'b1, 1'b0, 35);
    repeat (9) @(posedge clk);
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    issue(divu_i, 32'd100, 32'd7, 32'd14, 1'b1, 1'b0, 35);
    wait_done("post_rst_done");
    chk("post_rst_rd_lit", obs_rd, 32'd14);
    chk("post_rst_cycles_lit", 32'(obs_cyc), 32'd35);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
